// File: rtl/pong_vga_if.sv
// Game-core <-> renderer bundle: game state in, VGA pins and frame strobe out.
interface pong_vga_if;
  logic [9:0] player_paddle_y;
  logic [9:0] opponent_paddle_y;
  logic [9:0] ball_x;
  logic [9:0] ball_y;
  logic [7:0] score;
  logic       hsync;
  logic       vsync;
  logic [1:0] r;
  logic [1:0] g;
  logic [1:0] b;
  logic [7:0] vga_out;
  logic       frame_tick;

  // game core side
  modport master (
    output player_paddle_y, opponent_paddle_y, ball_x, ball_y, score,
    input  hsync, vsync, r, g, b, vga_out, frame_tick
  );

  // renderer side
  modport slave (
    input  player_paddle_y, opponent_paddle_y, ball_x, ball_y, score,
    output hsync, vsync, r, g, b, vga_out, frame_tick
  );
endinterface

// File: rtl/pong_vga_renderer.sv
// Pong VGA renderer: raster counters, per-frame shadow of the game state,
// two-stage shape/colour pipeline with syncs delayed to stay aligned.
module pong_vga_renderer #(
  parameter int SCREEN_WIDTH  = 640,
  parameter int SCREEN_HEIGHT = 480,
  parameter int BALL_SIZE     = 10,
  parameter int PADDLE_WIDTH  = 10,
  parameter int PADDLE_HEIGHT = 60,
  parameter int H_FP          = 16,
  parameter int H_SYNC        = 96,
  parameter int H_BP          = 48,
  parameter int V_FP          = 10,
  parameter int V_SYNC        = 2,
  parameter int V_BP          = 33
) (
  input  logic        clk,
  input  logic        rst_n,
  pong_vga_if.slave   io_vga
);

  localparam int H_TOTAL   = SCREEN_WIDTH + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL   = SCREEN_HEIGHT + V_FP + V_SYNC + V_BP;
  localparam int H_SYNC_LO = SCREEN_WIDTH + H_FP;
  localparam int H_SYNC_HI = H_SYNC_LO + H_SYNC;
  localparam int V_SYNC_LO = SCREEN_HEIGHT + V_FP;
  localparam int V_SYNC_HI = V_SYNC_LO + V_SYNC;

  // stage-1 record: shape hits plus raw timing for one pixel
  typedef struct packed {
    logic ball;
    logic paddle;
    logic opp_bar;
    logic ply_bar;
    logic net;
    logic active;
    logic hs;
    logic vs;
  } s1_t;

  localparam s1_t S1_RST = '{ball: 1'b0, paddle: 1'b0, opp_bar: 1'b0,
                             ply_bar: 1'b0, net: 1'b0, active: 1'b0,
                             hs: 1'b1, vs: 1'b1};

  logic [9:0] r_h_cnt, r_v_cnt;
  logic [9:0] r_ply_y, r_opp_y, r_ball_x, r_ball_y;
  logic [7:0] r_score;
  s1_t        r_s1;
  logic [5:0] r_rgb;
  logic       r_hs, r_vs;

  logic       w_h_last, w_v_last, w_load, w_frame_tick;
  logic [10:0] w_x, w_y, w_bx, w_by, w_oy, w_py;
  s1_t        w_s1;
  logic [5:0] w_rgb;

  assign w_h_last     = (r_h_cnt == 10'(H_TOTAL - 1));
  assign w_v_last     = (r_v_cnt == 10'(V_TOTAL - 1));
  // last active pixel of the frame: the next edge enters vertical blanking
  assign w_load       = w_h_last && (r_v_cnt == 10'(SCREEN_HEIGHT - 1));
  assign w_frame_tick = (r_h_cnt == 10'd0) && (r_v_cnt == 10'(SCREEN_HEIGHT));

  // raster counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (w_h_last) begin
      r_h_cnt <= '0;
      r_v_cnt <= w_v_last ? 10'd0 : r_v_cnt + 10'd1;
    end else begin
      r_h_cnt <= r_h_cnt + 10'd1;
    end
  end

  // shadow the game state once per frame so a frame never mixes two states
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ply_y  <= '0;
      r_opp_y  <= '0;
      r_ball_x <= '0;
      r_ball_y <= '0;
      r_score  <= '0;
    end else if (w_load) begin
      r_ply_y  <= io_vga.player_paddle_y;
      r_opp_y  <= io_vga.opponent_paddle_y;
      r_ball_x <= io_vga.ball_x;
      r_ball_y <= io_vga.ball_y;
      r_score  <= io_vga.score;
    end
  end

  // widen to 11 bits so ball/paddle extents never wrap
  assign w_x  = {1'b0, r_h_cnt};
  assign w_y  = {1'b0, r_v_cnt};
  assign w_bx = {1'b0, r_ball_x};
  assign w_by = {1'b0, r_ball_y};
  assign w_oy = {1'b0, r_opp_y};
  assign w_py = {1'b0, r_ply_y};

  // shape tests for the pixel the counters currently point at
  always_comb begin
    w_s1         = S1_RST;
    w_s1.ball    = (w_x >= w_bx) && (w_x <= w_bx + 11'(BALL_SIZE)) &&
                   (w_y >= w_by) && (w_y <= w_by + 11'(BALL_SIZE));
    w_s1.paddle  = ((w_x < 11'(PADDLE_WIDTH)) &&
                    (w_y >= w_oy) && (w_y < w_oy + 11'(PADDLE_HEIGHT))) ||
                   ((w_x >= 11'(SCREEN_WIDTH - PADDLE_WIDTH)) &&
                    (w_y >= w_py) && (w_y < w_py + 11'(PADDLE_HEIGHT)));
    // bars grow outward from the centre; a zero score gives an empty range
    w_s1.opp_bar = (w_y >= 11'd8) && (w_y < 11'd16) &&
                   (w_x >= 11'd304 - {4'b0, r_score[7:4], 3'b000}) &&
                   (w_x < 11'd304);
    w_s1.ply_bar = (w_y >= 11'd8) && (w_y < 11'd16) &&
                   (w_x >= 11'd336) &&
                   (w_x < 11'd336 + {4'b0, r_score[3:0], 3'b000});
    w_s1.net     = ((w_x == 11'd319) || (w_x == 11'd320)) && !r_v_cnt[4];
    w_s1.active  = (r_h_cnt < 10'(SCREEN_WIDTH)) && (r_v_cnt < 10'(SCREEN_HEIGHT));
    w_s1.hs      = !((r_h_cnt >= 10'(H_SYNC_LO)) && (r_h_cnt < 10'(H_SYNC_HI)));
    w_s1.vs      = !((r_v_cnt >= 10'(V_SYNC_LO)) && (r_v_cnt < 10'(V_SYNC_HI)));
  end

  // stage 1: register hits and raw syncs
  always_ff @(posedge clk) begin
    if (!rst_n) r_s1 <= S1_RST;
    else        r_s1 <= w_s1;
  end

  // colour priority, blanked outside the active area
  always_comb begin
    w_rgb = 6'b00_00_00;
    if (r_s1.active) begin
      if      (r_s1.ball)    w_rgb = 6'b11_11_00;
      else if (r_s1.paddle)  w_rgb = 6'b11_11_11;
      else if (r_s1.opp_bar) w_rgb = 6'b11_00_00;
      else if (r_s1.ply_bar) w_rgb = 6'b00_11_00;
      else if (r_s1.net)     w_rgb = 6'b01_01_01;
    end
  end

  // stage 2: registered pins
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rgb <= '0;
      r_hs  <= 1'b1;
      r_vs  <= 1'b1;
    end else begin
      r_rgb <= w_rgb;
      r_hs  <= r_s1.hs;
      r_vs  <= r_s1.vs;
    end
  end

  assign io_vga.r          = r_rgb[5:4];
  assign io_vga.g          = r_rgb[3:2];
  assign io_vga.b          = r_rgb[1:0];
  assign io_vga.hsync      = r_hs;
  assign io_vga.vsync      = r_vs;
  assign io_vga.frame_tick = w_frame_tick;
  assign io_vga.vga_out    = {r_hs, r_rgb[0], r_rgb[2], r_rgb[4],
                              r_vs, r_rgb[1], r_rgb[3], r_rgb[5]};

endmodule

// File: tb/tb_pong_vga_renderer.sv
// Bench: a full-size renderer for reset/line timing and a short-frame
// renderer (smaller height, porches, paddles) for frame-level behaviour.
module tb_pong_vga_renderer;

  localparam int SW = 640, SH = 20, BS = 4, PW = 10, PH = 8;
  localparam int HFP = 4, HSY = 8, HBP = 4, VFP = 2, VSY = 2, VBP = 2;
  localparam int LINE  = SW + HFP + HSY + HBP;        // 656
  localparam int FRAME = LINE * (SH + VFP + VSY + VBP); // 17056

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pong_vga_if bs();
  pong_vga_if bd();

  pong_vga_renderer #(
    .SCREEN_WIDTH(SW), .SCREEN_HEIGHT(SH), .BALL_SIZE(BS),
    .PADDLE_WIDTH(PW), .PADDLE_HEIGHT(PH),
    .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP)
  ) u_small (.clk(clk), .rst_n(rst_n), .io_vga(bs));

  pong_vga_renderer u_dflt (.clk(clk), .rst_n(rst_n), .io_vga(bd));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;

  // small-DUT monitors, sampled on the falling edge
  int n_ticks = 0, last_tick = -1;
  int hs_run = 0, hs_first = -1, vs_run = 0, vs_first = -1;
  always @(negedge clk) begin
    if (bs.frame_tick === 1'b1) begin
      n_ticks   <= n_ticks + 1;
      last_tick <= cyc;
    end
    if (bs.hsync === 1'b0) hs_run <= hs_run + 1;
    else begin
      if (hs_run != 0 && hs_first < 0) hs_first <= hs_run;
      hs_run <= 0;
    end
    if (bs.vsync === 1'b0) vs_run <= vs_run + 1;
    else begin
      if (vs_run != 0 && vs_first < 0) vs_first <= vs_run;
      vs_run <= 0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic set_in(input int ply, input int opp, input int bx, input int by, input int sc);
    bs.player_paddle_y   = 10'(ply);
    bs.opponent_paddle_y = 10'(opp);
    bs.ball_x            = 10'(bx);
    bs.ball_y            = 10'(by);
    bs.score             = 8'(sc);
  endtask

  typedef struct {
    int         f;
    int         y;
    int         x;
    logic [5:0] exp;
    bit         swap;
  } vec_t;

  localparam logic [5:0] BLK = 6'b00_00_00, YEL = 6'b11_11_00, WHT = 6'b11_11_11;
  localparam logic [5:0] RED = 6'b11_00_00, GRN = 6'b00_11_00, GRY = 6'b01_01_01;

  vec_t vec[36];

  initial begin
    int t, rel, c1, t1, e, r;

    // frame 1 shows state A: ball (320,12), paddles row 2, score 0x31
    vec[0]  = '{1, 0, 0,   BLK, 1'b0};
    vec[1]  = '{1, 0, 319, GRY, 1'b0};
    vec[2]  = '{1, 0, 320, GRY, 1'b0};
    vec[3]  = '{1, 0, 321, BLK, 1'b0};
    vec[4]  = '{1, 2, 0,   WHT, 1'b0};
    vec[5]  = '{1, 2, 9,   WHT, 1'b0};
    vec[6]  = '{1, 2, 10,  BLK, 1'b0};
    vec[7]  = '{1, 2, 629, BLK, 1'b0};
    vec[8]  = '{1, 2, 630, WHT, 1'b0};
    vec[9]  = '{1, 2, 639, WHT, 1'b0};
    vec[10] = '{1, 8, 279, BLK, 1'b0};
    vec[11] = '{1, 8, 280, RED, 1'b0};
    vec[12] = '{1, 8, 303, RED, 1'b0};
    vec[13] = '{1, 8, 304, BLK, 1'b0};
    vec[14] = '{1, 8, 319, GRY, 1'b0};
    vec[15] = '{1, 8, 336, GRN, 1'b0};
    vec[16] = '{1, 8, 343, GRN, 1'b0};
    vec[17] = '{1, 8, 344, BLK, 1'b0};
    vec[18] = '{1, 9, 0,   WHT, 1'b0};
    vec[19] = '{1, 10, 0,  BLK, 1'b0};
    // inputs switch to state B here; rest of frame 1 must still show A
    vec[20] = '{1, 12, 319, GRY, 1'b1};
    vec[21] = '{1, 12, 320, YEL, 1'b0};
    vec[22] = '{1, 12, 324, YEL, 1'b0};
    vec[23] = '{1, 12, 325, BLK, 1'b0};
    vec[24] = '{1, 15, 300, RED, 1'b0};
    vec[25] = '{1, 16, 319, BLK, 1'b0};
    vec[26] = '{1, 16, 320, YEL, 1'b0};
    vec[27] = '{1, 17, 320, BLK, 1'b0};
    // frame 2 shows state B: ball (632,3) over player paddle, score 0
    vec[28] = '{2, 2, 635, WHT, 1'b0};
    vec[29] = '{2, 3, 631, WHT, 1'b0};
    vec[30] = '{2, 3, 632, YEL, 1'b0};
    vec[31] = '{2, 5, 635, YEL, 1'b0};
    vec[32] = '{2, 5, 636, YEL, 1'b0};
    vec[33] = '{2, 5, 637, WHT, 1'b0};
    vec[34] = '{2, 8, 280, BLK, 1'b0};
    vec[35] = '{2, 8, 319, GRY, 1'b0};

    bd.player_paddle_y = '0; bd.opponent_paddle_y = '0;
    bd.ball_x = '0; bd.ball_y = '0; bd.score = '0;
    set_in(0, 0, 0, 0, 0);

    // reset held for 5 edges
    rst_n = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_hsync",  bs.hsync, 1);
    chk("rst_vsync",  bs.vsync, 1);
    chk("rst_rgb",    {bs.r, bs.g, bs.b}, 0);
    chk("rst_tick",   bs.frame_tick, 0);
    chk("rst_vgaout", bs.vga_out, 8'b1000_1000);
    chk("rst_dflt_hsync", bd.hsync, 1);
    chk("rst_dflt_vsync", bd.vsync, 1);
    chk("rst_dflt_rgb",   {bd.r, bd.g, bd.b}, 0);
    chk("rst_dflt_tick",  bd.frame_tick, 0);

    set_in(2, 2, 320, 12, 8'h31);
    rel = cyc;
    rst_n = 1'b1;

    // full-size line timing
    t = 0;
    while (bd.hsync !== 1'b0 && t < 2000) begin @(posedge clk); #1; t++; end
    chk("dflt_first_hs_fall", cyc - rel, 658);
    c1 = cyc;
    t = 0;
    while (bd.hsync !== 1'b1 && t < 2000) begin @(posedge clk); #1; t++; end
    chk("dflt_hs_low_len", cyc - c1, 96);
    t = 0;
    while (bd.hsync !== 1'b0 && t < 2000) begin @(posedge clk); #1; t++; end
    chk("dflt_hs_period", cyc - c1, 800);
    chk("dflt_vsync_high", bd.vsync, 1);

    // first frame tick of the short-frame DUT
    t = 0;
    while (n_ticks < 1 && t < 3 * FRAME) begin @(posedge clk); #1; t++; end
    chk("tick1_time", last_tick - rel, SH * LINE);
    t1 = last_tick;

    for (int i = 0; i < 36; i++) begin
      if (vec[i].swap) set_in(2, 2, 632, 3, 8'h00);
      wait_until(t1 + (vec[i].f - 1) * FRAME + FRAME - SH * LINE
                 + vec[i].y * LINE + vec[i].x + 2);
      chk($sformatf("pix_f%0d_y%0d_x%0d", vec[i].f, vec[i].y, vec[i].x),
          {bs.r, bs.g, bs.b}, vec[i].exp);
    end

    chk("tick_count_2", n_ticks, 2);
    chk("frame_period", last_tick - t1, FRAME);
    chk("hs_low_len", hs_first, HSY);
    chk("vs_low_len", vs_first, VSY * LINE);

    // mid-frame reset with counters at (321,10) of frame 2
    e = t1 + FRAME + (FRAME - SH * LINE) + 10 * LINE + 321;
    wait_until(e);
    chk("pre_rst_net", {bs.r, bs.g, bs.b}, GRY);
    rst_n = 1'b0;
    @(posedge clk); #1;
    r = cyc;
    chk("mid_rst_rgb",   {bs.r, bs.g, bs.b}, 0);
    chk("mid_rst_hsync", bs.hsync, 1);
    chk("mid_rst_vsync", bs.vsync, 1);
    chk("mid_rst_tick",  bs.frame_tick, 0);
    rst_n = 1'b1;

    t = 0;
    while (bs.hsync !== 1'b0 && t < 2000) begin @(posedge clk); #1; t++; end
    chk("post_rst_hs_fall", cyc - r, SW + HFP + 2);

    // shadows were cleared: ball and both paddles sit at the origin
    wait_until(r + 2 * LINE + 2 + 2);
    chk("post_rst_shadow_pix", {bs.r, bs.g, bs.b}, YEL);

    t = 0;
    while (n_ticks < 3 && t < 2 * FRAME) begin @(posedge clk); #1; t++; end
    chk("post_rst_tick_time", last_tick - r, SH * LINE);
    chk("tick_count_3", n_ticks, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pong_vga_renderer.md
# pong_vga_renderer

Converts the Pong game state into a 640x480 @ 60 Hz VGA stream: sync timing, per-pixel colour for paddles, ball, centre net and score bars. It sits directly downstream of the Pong game core and consumes its paddle, ball and score outputs. It also returns a once-per-frame tick the game core uses as its update strobe. It drives the 2-bit-per-channel VGA output pins (TinyVGA order).

## Interface
Parameters:
- SCREEN_WIDTH, 640, active pixels per line
- SCREEN_HEIGHT, 480, active lines per frame
- BALL_SIZE, 10, ball extent; box is inclusive, ball_x..ball_x+BALL_SIZE
- PADDLE_WIDTH, 10, paddle width in pixels
- PADDLE_HEIGHT, 60, paddle height in pixels

Ports:
- clk  in  1  pixel clock, 25.175 MHz nominal
- rst_n  in  1  reset: synchronous, active-low
- player_paddle_y  in  10  player paddle top row, right edge
- opponent_paddle_y  in  10  opponent paddle top row, left edge
- ball_x  in  10  ball left column
- ball_y  in  10  ball top row
- score  in  8  [7:4] opponent, [3:0] player
- hsync  out  1  active-low horizontal sync
- vsync  out  1  active-low vertical sync
- r, g, b  out  2 each  colour, each channel 2 bits
- vga_out  out  8  {hsync, b[0], g[0], r[0], vsync, b[1], g[1], r[1]}
- frame_tick  out  1  one-cycle pulse at the start of vertical blanking

## Operation
- h_cnt counts 0..799, then wraps to 0. When h_cnt wraps, v_cnt increments, counting 0..524, then wraps.
- Horizontal: active 0..639, front porch 640..655, sync 656..751 (hsync low), back porch 752..799.
- Vertical: active 0..479, front porch 480..489, sync 490..491 (vsync low), back porch 492..524.
- Shadow registers and frame_tick:
  - On the edge where the counters go from (799,479) to (0,480), all five game inputs load into shadow registers.
  - frame_tick is high for exactly that one cycle (counters at (0,480)).
  - Inputs are ignored at every other time, so there is no tearing.
- Shape tests (x = h_cnt, y = v_cnt); all comparisons are 11-bit, so sums never wrap:
  - Ball: ball_x <= x <= ball_x+BALL_SIZE and ball_y <= y <= ball_y+BALL_SIZE.
  - Opponent paddle: x < PADDLE_WIDTH and opp_y <= y < opp_y+PADDLE_HEIGHT.
  - Player paddle: x >= SCREEN_WIDTH-PADDLE_WIDTH and ply_y <= y < ply_y+PADDLE_HEIGHT.
  - Score rows: 8 <= y < 16.
    - Opponent bar: 304-8*opp <= x < 304.
    - Player bar: 336 <= x < 336+8*ply.
    - A score of 0 draws nothing.
  - Net: x in {319, 320} and y[4] == 0 (16-line dashes).
- Colour priority, first match wins ({r,g,b}):
  - ball: 11,11,00
  - paddle: 11,11,11
  - opponent bar: 11,00,00
  - player bar: 00,11,00
  - net: 01,01,01
  - otherwise: 00,00,00
- Outside the active area rgb = 0 regardless of shape hits.
- Off-screen input values (e.g. ball_x >= 640) simply draw nothing beyond the active area. No clamping.

## Timing
- Pipeline stages:
  - Stage 0: counters.
  - Stage 1: registered shape hits, active flag, raw syncs.
  - Stage 2: registered rgb, hsync, vsync.
- Outputs for counter position (h,v) appear 2 cycles after the counters hold (h,v). Syncs are delayed identically, so colour and syncs stay aligned.
- frame_tick is not pipelined; it aligns with the counters.
- Reset, applied at any time including mid-frame, takes effect on the next clock edge:
  - h_cnt = v_cnt = 0, all pipeline stages cleared.
  - hsync = vsync = 1, rgb = 0, frame_tick = 0, shadow registers = 0.
- Release: counting resumes from (0,0). The first valid pixel appears 2 cycles after the first post-reset edge.
- Frame period: 420000 clocks. Line period: 800 clocks.

## Test plan
- Reset for 5 cycles, then release → hsync = vsync = 1, rgb = 0, frame_tick = 0 during reset. After release, the first hsync falling edge comes 656+2 cycles later.
- Free-run 2 frames → hsync low for 96 cycles every 800. vsync low for 1600 cycles every 420000. frame_tick pulses exactly once per 420000 cycles.
- Load ball (320,240), paddles 210/210, score 0x00; wait for a frame_tick → on the next frame:
  - rgb = yellow at (320..330, 240..250).
  - White at (0..9, 210..269) and (630..639, 210..269).
  - Net grey at (319, 0..15), black at (319, 16..31).
- Score 0x31 → opponent bar red at x 280..303 and player bar green at x 336..343, both on rows 8..15. x = 279 and x = 344 are black.
- Ball (632,215), player paddle 210 → pixel (635,220) is yellow (ball beats paddle). Change ball_x mid-frame → output is unchanged until after the next frame_tick.
- Assert rst_n low at (400,300) for 1 cycle → outputs reset on the next edge, counters restart at (0,0), next frame_tick comes 384000 cycles after release.
